// File: rtl/lsu_ram_ctrl.sv
// Load/store sequencer in front of the ram_2 data memory: byte-lane masking,
// split handling for word-crossing accesses, and load merge/extension.
module lsu_ram_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] load_data,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdat,
   output logic        ram_we,
   output logic        ram_re,
   output logic [3:0]  ram_type,
   input  logic [31:0] ram_rdata
);

   // state  | meaning
   // IDLE   | waiting for req_valid; illegal funct3 answered from here
   // LO     | access to the word holding the first byte
   // HI     | access to the following word (split accesses only)
   // RESP   | load result merged and extended; done follows
   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic        split_q, split_d;
   logic [3:0]  hi_type_q, hi_type_d;
   logic [31:0] hi_wdat_q, hi_wdat_d;
   logic [31:0] lo_word_q, lo_word_d;
   logic [31:0] load_data_q, load_data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [31:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdat_q, ram_wdat_d;
   logic        ram_we_q, ram_we_d;
   logic        ram_re_q, ram_re_d;
   logic [3:0]  ram_type_q, ram_type_d;

   logic        legal;
   logic [7:0]  base_mask, mask;
   logic [31:0] wmask;
   logic [63:0] sdata;
   logic [55:0] merged;
   logic [31:0] sel;
   logic [31:0] ext;

   always_comb begin
      base_mask = 8'h00;
      wmask     = 32'h0;
      case (req_funct3[1:0])
         2'b00:   begin base_mask = 8'h01; wmask = 32'h0000_00FF; end
         2'b01:   begin base_mask = 8'h03; wmask = 32'h0000_FFFF; end
         2'b10:   begin base_mask = 8'h0F; wmask = 32'hFFFF_FFFF; end
         default: begin base_mask = 8'h00; wmask = 32'h0; end
      endcase
      if (req_we)
         legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
      else
         legal = (req_funct3[1:0] != 2'b11) && !(req_funct3[2] && req_funct3[1]);
      mask  = base_mask << req_addr[1:0];
      sdata = {32'h0, req_wdata & wmask} << {req_addr[1:0], 3'b000};
   end

   // Only the low 24 bits of the high word can ever reach the result.
   always_comb begin
      merged = {split_q ? ram_rdata[23:0] : 24'h0, split_q ? lo_word_q : ram_rdata};
      case (off_q)
         2'd0:    sel = merged[31:0];
         2'd1:    sel = merged[39:8];
         2'd2:    sel = merged[47:16];
         default: sel = merged[55:24];
      endcase
      case (funct3_q)
         3'b000:  ext = {{24{sel[7]}}, sel[7:0]};
         3'b001:  ext = {{16{sel[15]}}, sel[15:0]};
         3'b100:  ext = {24'h0, sel[7:0]};
         3'b101:  ext = {16'h0, sel[15:0]};
         default: ext = sel;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      split_d     = split_q;
      hi_type_d   = hi_type_q;
      hi_wdat_d   = hi_wdat_q;
      lo_word_d   = lo_word_q;
      load_data_d = load_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      ram_addr_d  = 32'h0;
      ram_wdat_d  = 32'h0;
      ram_we_d    = 1'b0;
      ram_re_d    = 1'b0;
      ram_type_d  = 4'h0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d      = req_we;
               funct3_d  = req_funct3;
               off_d     = req_addr[1:0];
               split_d   = (mask[7:4] != 4'h0);
               hi_type_d = mask[7:4];
               hi_wdat_d = sdata[63:32];
               if (legal) begin
                  state_d    = S_LO;
                  ram_addr_d = {req_addr[31:2], 2'b00};
                  ram_wdat_d = sdata[31:0];
                  ram_type_d = mask[3:0];
                  ram_we_d   = req_we;
                  ram_re_d   = !req_we;
               end else begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end
            end
         end
         S_LO: begin
            if (split_q) begin
               state_d    = S_HI;
               ram_addr_d = ram_addr_q + 32'd4;
               ram_wdat_d = hi_wdat_q;
               ram_type_d = hi_type_q;
               ram_we_d   = we_q;
               ram_re_d   = !we_q;
            end else begin
               state_d = S_RESP;
            end
         end
         S_HI: begin
            lo_word_d = ram_rdata;
            state_d   = S_RESP;
         end
         default: begin
            if (!we_q)
               load_data_d = ext;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'h0;
         off_q       <= 2'h0;
         split_q     <= 1'b0;
         hi_type_q   <= 4'h0;
         hi_wdat_q   <= 32'h0;
         lo_word_q   <= 32'h0;
         load_data_q <= 32'h0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ram_addr_q  <= 32'h0;
         ram_wdat_q  <= 32'h0;
         ram_we_q    <= 1'b0;
         ram_re_q    <= 1'b0;
         ram_type_q  <= 4'h0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         split_q     <= split_d;
         hi_type_q   <= hi_type_d;
         hi_wdat_q   <= hi_wdat_d;
         lo_word_q   <= lo_word_d;
         load_data_q <= load_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdat_q  <= ram_wdat_d;
         ram_we_q    <= ram_we_d;
         ram_re_q    <= ram_re_d;
         ram_type_q  <= ram_type_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign load_data = load_data_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdat  = ram_wdat_q;
   assign ram_we    = ram_we_q;
   assign ram_re    = ram_re_q;
   assign ram_type  = ram_type_q;

endmodule

// File: tb/tb_lsu_ram_ctrl.sv
// Directed bench for lsu_ram_ctrl with a small byte-lane RAM model behind it.
module tb_lsu_ram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        busy, done, err;
   logic [31:0] load_data, ram_addr, ram_wdat, ram_rdata;
   logic        ram_we, ram_re;
   logic [3:0]  ram_type;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mem [64];

   logic        o_busy [1:6];
   logic        o_done [1:6];
   logic        o_err  [1:6];
   logic        o_we   [1:6];
   logic [31:0] o_addr [1:6];
   logic [31:0] o_wdat [1:6];
   logic [3:0]  o_type [1:6];
   logic [31:0] o_ld   [1:6];
   int          we_cnt, re_cnt, done_at;

   always #5 clk = ~clk;

   lsu_ram_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .load_data  (load_data),
      .ram_addr   (ram_addr),
      .ram_wdat   (ram_wdat),
      .ram_we     (ram_we),
      .ram_re     (ram_re),
      .ram_type   (ram_type),
      .ram_rdata  (ram_rdata)
   );

   // Registered-read RAM; word index from addr[7:2] keeps the test addresses distinct.
   always @(posedge clk) begin
      if (ram_re)
         ram_rdata <= mem[ram_addr[7:2]];
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_type[b])
               mem[ram_addr[7:2]][8*b +: 8] = ram_wdat[8*b +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int rst_at);
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      we_cnt  = 0;
      re_cnt  = 0;
      done_at = 0;
      for (int c = 1; c <= 6; c++) begin
         o_busy[c] = busy;
         o_done[c] = done;
         o_err[c]  = err;
         o_we[c]   = ram_we;
         o_addr[c] = ram_addr;
         o_wdat[c] = ram_wdat;
         o_type[c] = ram_type;
         o_ld[c]   = load_data;
         if (ram_we) we_cnt++;
         if (ram_re) re_cnt++;
         if (done && done_at == 0) done_at = c;
         if (c == rst_at) rst_n = 1'b0;
         if (rst_at != 0 && c == rst_at + 1) rst_n = 1'b1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp, input int exp_done);
      run_req(1'b0, f3, a, 32'h0, 0);
      chk({tag, "_data"}, load_data, exp);
      chk({tag, "_done"}, done_at, exp_done);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h0;
      ram_rdata  = 32'h0;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'h0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", 32'({busy, done, err, ram_we, ram_re, ram_type}), 32'h0);
      chk("rst_addr", ram_addr, 32'h0);
      chk("rst_wdat", ram_wdat, 32'h0);
      chk("rst_ld", load_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // aligned SW
      run_req(1'b1, 3'b010, 32'h1024_0040, 32'h123D_F556, 0);
      chk("sw_busy1", 32'(o_busy[1]), 32'h1);
      chk("sw_we1", 32'(o_we[1]), 32'h1);
      chk("sw_addr", o_addr[1], 32'h1024_0040);
      chk("sw_type", 32'(o_type[1]), 32'hF);
      chk("sw_wdat", o_wdat[1], 32'h123D_F556);
      chk("sw_wecnt", we_cnt, 1);
      chk("sw_recnt", re_cnt, 0);
      chk("sw_done", done_at, 3);
      chk("sw_err", 32'(o_err[3]), 32'h0);
      chk("sw_type_resp", 32'(o_type[2]), 32'h0);
      chk("sw_ld_kept", load_data, 32'h0);

      run_req(1'b1, 3'b010, 32'h1024_0044, 32'h89AB_CDEF, 0);
      run_req(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h1122_3344, 0);
      run_req(1'b1, 3'b010, 32'h0000_0000, 32'h5566_7788, 0);
      chk("mem_pre", mem[17], 32'h89AB_CDEF);

      do_load("lb",  3'b000, 32'h1024_0041, 32'hFFFF_FFF5, 3);
      do_load("lbu", 3'b100, 32'h1024_0041, 32'h0000_00F5, 3);
      do_load("lh",  3'b001, 32'h1024_0040, 32'hFFFF_F556, 3);
      do_load("lhu", 3'b101, 32'h1024_0042, 32'h0000_123D, 3);

      // split load across 0x40/0x44
      do_load("lw_split", 3'b010, 32'h1024_0042, 32'hCDEF_123D, 4);
      chk("lw_split_re", re_cnt, 2);
      chk("lw_split_t1", 32'(o_type[1]), 32'hC);
      chk("lw_split_a2", o_addr[2], 32'h1024_0044);
      chk("lw_split_t2", 32'(o_type[2]), 32'h3);

      // address wrap on the high half
      do_load("lw_wrap", 3'b010, 32'hFFFF_FFFE, 32'h7788_1122, 4);
      chk("wrap_a1", o_addr[1], 32'hFFFF_FFFC);
      chk("wrap_a2", o_addr[2], 32'h0000_0000);

      // split SH
      run_req(1'b1, 3'b001, 32'h1024_0043, 32'h0000_ABCD, 0);
      chk("sh_a1", o_addr[1], 32'h1024_0040);
      chk("sh_t1", 32'(o_type[1]), 32'h8);
      chk("sh_w1", o_wdat[1], 32'hCD00_0000);
      chk("sh_a2", o_addr[2], 32'h1024_0044);
      chk("sh_t2", 32'(o_type[2]), 32'h1);
      chk("sh_w2", o_wdat[2], 32'h0000_00AB);
      chk("sh_done", done_at, 4);
      chk("sh_ld_kept", load_data, 32'h7788_1122);
      do_load("rd40", 3'b010, 32'h1024_0040, 32'hCD3D_F556, 3);
      do_load("rd44", 3'b010, 32'h1024_0044, 32'h89AB_CDAB, 3);

      // illegal funct3
      run_req(1'b0, 3'b011, 32'h1024_0040, 32'h0, 0);
      chk("ill_ld_done", done_at, 1);
      chk("ill_ld_err", 32'(o_err[1]), 32'h1);
      chk("ill_ld_busy", 32'(o_busy[1]), 32'h0);
      chk("ill_ld_ram", we_cnt + re_cnt, 0);
      chk("ill_ld_kept", load_data, 32'h89AB_CDAB);
      run_req(1'b1, 3'b100, 32'h1024_0040, 32'hFFFF_FFFF, 0);
      chk("ill_st_done", done_at, 1);
      chk("ill_st_err", 32'(o_err[1]), 32'h1);
      chk("ill_st_ram", we_cnt + re_cnt, 0);

      // reset during the LO cycle of a split SH
      run_req(1'b1, 3'b001, 32'h1024_0043, 32'h0000_1234, 1);
      chk("rst_mid_ctl", 32'({o_busy[2], o_done[2], o_err[2], o_we[2], o_type[2]}), 32'h0);
      chk("rst_mid_addr", o_addr[2], 32'h0);
      chk("rst_mid_wdat", o_wdat[2], 32'h0);
      chk("rst_mid_ld", o_ld[2], 32'h0);
      chk("rst_mid_we", we_cnt, 1);
      run_req(1'b1, 3'b010, 32'h1024_0048, 32'hA5A5_A5A5, 0);
      chk("post_rst_done", done_at, 3);
      chk("post_rst_addr", o_addr[1], 32'h1024_0048);
      do_load("hi_unwritten", 3'b010, 32'h1024_0044, 32'h89AB_CDAB, 3);
      do_load("lo_written", 3'b010, 32'h1024_0040, 32'h343D_F556, 3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
